// File: rtl/stall_ctrl.sv
// Pipeline hazard controller: stall bus priority, post-jump flush sequencing, deadlock watchdog.
// Latency: stall_out/flush_out combinational same cycle; jump_pending_out/deadlock_out registered.
// Backpressure: rdy_in=0 freezes all stages and flush sequencing. Define STALL_PERF_EN for stall/flush counters.
module stall_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int WDT_LIMIT    = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy_in,
    input  logic        stallreq_if,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic        jump_or_not,
    output logic [5:0]  stall_out,
    output logic        flush_out,
    output logic        jump_pending_out,
    output logic        deadlock_out,
    output logic [31:0] stall_cycles_out,
    output logic [31:0] flush_count_out
);

    typedef enum logic [1:0] {RUN, DEFER, FLUSH} state_t;

    localparam int CNT_W = 3;
    localparam int WDT_W = (WDT_LIMIT > 2) ? $clog2(WDT_LIMIT) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [WDT_W-1:0] WDT_MAX    = WDT_W'(WDT_LIMIT - 1);
    localparam state_t AFTER_FLUSH = (FLUSH_CYCLES > 1) ? FLUSH : RUN;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [WDT_W-1:0] wdt;
    logic             hold_ex;
    logic             flush;
    logic             stalled;

    // EX (and everything behind it) is held: a resolved jump cannot flush yet
    assign hold_ex = ~rdy_in | stallreq_mem | stallreq_ex;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        flush     = 1'b0;
        case (state)
            RUN: begin
                if (jump_or_not && !hold_ex) begin
                    flush     = 1'b1;
                    state_nxt = AFTER_FLUSH;
                    cnt_nxt   = CNT_RELOAD;
                end else if (jump_or_not) begin
                    state_nxt = DEFER;
                end
            end
            DEFER: begin
                if (!hold_ex) begin
                    flush     = 1'b1;
                    state_nxt = AFTER_FLUSH;
                    cnt_nxt   = CNT_RELOAD;
                end
            end
            FLUSH: begin
                if (rdy_in) begin
                    flush = 1'b1;
                    if (jump_or_not) begin
                        cnt_nxt = CNT_RELOAD;
                    end else begin
                        cnt_nxt = cnt - 3'd1;
                        if (cnt == 3'd1)
                            state_nxt = RUN;
                    end
                end
            end
            default: state_nxt = RUN;
        endcase
        if (rst)
            flush = 1'b0;
    end

    // Fetch stall is dropped during a flush: that fetch is on the wrong path anyway
    always_comb begin
        stall_out = 6'b000000;
        if (rst)
            stall_out = 6'b000000;
        else if (!rdy_in)
            stall_out = 6'b111111;
        else if (stallreq_mem)
            stall_out = 6'b011111;
        else if (stallreq_ex)
            stall_out = 6'b001111;
        else if (stallreq_id)
            stall_out = 6'b000111;
        else if (stallreq_if && !flush)
            stall_out = 6'b000011;
    end

    assign flush_out        = flush;
    assign stalled          = (stall_out != 6'b000000);
    assign jump_pending_out = (state == DEFER);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            cnt          <= '0;
            wdt          <= '0;
            deadlock_out <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (!stalled)
                wdt <= '0;
            else if (rdy_in && wdt != WDT_MAX)
                wdt <= wdt + 1'b1;
            if (stalled && wdt == WDT_MAX)
                deadlock_out <= 1'b1;
        end
    end

`ifdef STALL_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    // A flush sequence starts from RUN or DEFER; reloads inside FLUSH are not new sequences
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stalled)
                stall_cnt <= stall_cnt + 32'd1;
            if (flush && state != FLUSH)
                flush_cnt <= flush_cnt + 32'd1;
        end
    end

    assign stall_cycles_out = stall_cnt;
    assign flush_count_out  = flush_cnt;
`else
    assign stall_cycles_out = 32'd0;
    assign flush_count_out  = 32'd0;
`endif

endmodule

// File: tb/tb_stall_ctrl.sv
// Directed bench: instance a uses default parameters, instance b uses FLUSH_CYCLES=2, WDT_LIMIT=4.
module tb_stall_ctrl;

    logic        clk;
    logic        rst;
    logic        rdy_in, stallreq_if, stallreq_id, stallreq_ex, stallreq_mem, jump_or_not;
    logic [5:0]  stall_a, stall_b;
    logic        flush_a, flush_b, pend_a, pend_b, dead_a, dead_b;
    logic [31:0] sc_a, fc_a, sc_b, fc_b;

    int errors = 0;
    int checks = 0;

`ifdef STALL_PERF_EN
    localparam logic [31:0] EXP_SC = 32'd3;
    localparam logic [31:0] EXP_FC = 32'd2;
`else
    localparam logic [31:0] EXP_SC = 32'd0;
    localparam logic [31:0] EXP_FC = 32'd0;
`endif

    stall_ctrl u_a (
        .clk(clk), .rst(rst), .rdy_in(rdy_in),
        .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
        .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
        .jump_or_not(jump_or_not),
        .stall_out(stall_a), .flush_out(flush_a), .jump_pending_out(pend_a),
        .deadlock_out(dead_a), .stall_cycles_out(sc_a), .flush_count_out(fc_a)
    );

    stall_ctrl #(.FLUSH_CYCLES(2), .WDT_LIMIT(4)) u_b (
        .clk(clk), .rst(rst), .rdy_in(rdy_in),
        .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
        .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
        .jump_or_not(jump_or_not),
        .stall_out(stall_b), .flush_out(flush_b), .jump_pending_out(pend_b),
        .deadlock_out(dead_b), .stall_cycles_out(sc_b), .flush_count_out(fc_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       rdy, mem, ex, id, fi;
        logic [5:0] exp_stall;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rdy, input logic mem, input logic ex,
                         input logic id, input logic fi, input logic jmp);
        rdy_in       = rdy;
        stallreq_mem = mem;
        stallreq_ex  = ex;
        stallreq_id  = id;
        stallreq_if  = fi;
        jump_or_not  = jmp;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    vec_t vecs[10];

    initial begin
        logic [7:0] mem_p, jmp_p, pend_e, fla_e, flb_e, ex_p, dead_e;

        vecs[0] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 6'b111111};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b111111};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 6'b011111};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 6'b001111};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 6'b000111};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'b000011};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000};
        vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'b011111};
        vecs[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'b001111};
        vecs[9] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'b000111};

        // Reset with every request asserted
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        next_cycle();
        @(negedge clk);
        check("rst_stall", 32'(stall_a), 32'h0);
        check("rst_flush", 32'(flush_a), 32'h0);
        check("rst_pend", 32'(pend_a), 32'h0);
        check("rst_dead", 32'(dead_a), 32'h0);
        check("rst_sc", sc_a, 32'h0);
        check("rst_fc", fc_a, 32'h0);
        next_cycle();
        rst = 1'b0;
        jump_or_not = 1'b0;
        @(negedge clk);
        check("rel_stall", 32'(stall_a), 32'h1f);
        check("rel_flush", 32'(flush_a), 32'h0);

        // Priority table, no jumps
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].rdy, vecs[i].mem, vecs[i].ex, vecs[i].id, vecs[i].fi, 1'b0);
            @(negedge clk);
            check($sformatf("vec%0d_stall", i), 32'(stall_a), 32'(vecs[i].exp_stall));
            check($sformatf("vec%0d_flush", i), 32'(flush_a), 32'h0);
            next_cycle();
        end

        // Single-cycle ID request
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check("id_on", 32'(stall_a), 32'h07);
        next_cycle();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("id_off", 32'(stall_a), 32'h00);

        // Two-cycle flush masks fetch stall (instance b)
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        check("f2_c0_flush", 32'(flush_b), 32'h1);
        check("f2_c0_stall", 32'(stall_b), 32'h00);
        check("f1_c0_flush", 32'(flush_a), 32'h1);
        next_cycle();
        jump_or_not = 1'b0;
        @(negedge clk);
        check("f2_c1_flush", 32'(flush_b), 32'h1);
        check("f2_c1_stall", 32'(stall_b), 32'h00);
        check("f1_c1_flush", 32'(flush_a), 32'h0);
        check("f1_c1_stall", 32'(stall_a), 32'h03);
        next_cycle();
        @(negedge clk);
        check("f2_c2_flush", 32'(flush_b), 32'h0);
        check("f2_c2_stall", 32'(stall_b), 32'h03);

        // Jump deferred behind MEM stall; second jump in DEFER merges
        do_reset();
        mem_p  = 8'b00001111;
        jmp_p  = 8'b00001010;
        pend_e = 8'b00011100;
        fla_e  = 8'b00010000;
        flb_e  = 8'b00110000;
        for (int c = 0; c < 7; c++) begin
            drive(1'b1, mem_p[c], 1'b0, 1'b0, 1'b0, jmp_p[c]);
            @(negedge clk);
            check($sformatf("defer_c%0d_pend", c), 32'(pend_a), 32'(pend_e[c]));
            check($sformatf("defer_c%0d_flush_a", c), 32'(flush_a), 32'(fla_e[c]));
            check($sformatf("defer_c%0d_flush_b", c), 32'(flush_b), 32'(flb_e[c]));
            next_cycle();
        end

        // rdy_in low freezes an active flush (instance b)
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check("frz_c0_flush", 32'(flush_b), 32'h1);
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("frz_c1_flush", 32'(flush_b), 32'h0);
        check("frz_c1_stall", 32'(stall_b), 32'h3f);
        next_cycle();
        rdy_in = 1'b1;
        @(negedge clk);
        check("frz_c2_flush", 32'(flush_b), 32'h1);
        next_cycle();
        @(negedge clk);
        check("frz_c3_flush", 32'(flush_b), 32'h0);

        // Watchdog: EX held six cycles with WDT_LIMIT=4
        do_reset();
        ex_p   = 8'b00111111;
        dead_e = 8'b11110000;
        for (int c = 0; c < 8; c++) begin
            drive(1'b1, 1'b0, ex_p[c], 1'b0, 1'b0, 1'b0);
            @(negedge clk);
            check($sformatf("wdt_c%0d", c), 32'(dead_b), 32'(dead_e[c]));
            next_cycle();
        end
        @(negedge clk);
        check("wdt_a_quiet", 32'(dead_a), 32'h0);
        do_reset();
        @(negedge clk);
        check("wdt_cleared", 32'(dead_b), 32'h0);

        // Statistics: three stall cycles and two jumps
        next_cycle();
        do_reset();
        for (int c = 0; c < 7; c++) begin
            drive(1'b1, 1'b0, 1'b0, (c < 3) ? 1'b1 : 1'b0, 1'b0, (c == 3 || c == 5) ? 1'b1 : 1'b0);
            next_cycle();
        end
        @(negedge clk);
        check("perf_sc_a", sc_a, EXP_SC);
        check("perf_fc_a", fc_a, EXP_FC);
        check("perf_sc_b", sc_b, EXP_SC);
        check("perf_fc_b", fc_b, EXP_FC);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
